sseg_scan_ctrl: RTL and testbench
=================================

# sseg_scan_ctrl

Parametrised multiplexed seven-segment scan controller, the successor to the fixed 4-digit display FSM. It time-multiplexes NUM_DIGITS pre-encoded digit patterns onto one shared segment bus and a one-hot active-low anode bus. Beyond the 4-digit block it adds a programmable slot-rate prescaler, per-digit decimal point and blanking, PWM brightness control and an anti-ghosting guard cycle. It sits between the stopwatch digit encoders and the board pins.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits; legal range 2..8.
- DIV, 100000: clk cycles per digit slot; minimum 2.
- BRIGHT_W, 4: width of the brightness control.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- seg_in  in  7*NUM_DIGITS  digit k pattern at bits [7k+6:7k]; already active-low segment encoding, passed through unchanged.
- dp_in  in  NUM_DIGITS  1 = decimal point of digit k lit.
- blank_in  in  NUM_DIGITS  1 = digit k dark for its whole slot.
- brightness  in  BRIGHT_W  on-time per slot; all-ones = full on, 0 = off.
- an  out  NUM_DIGITS  active-low anodes, at most one bit low.
- sseg  out  7  active-low segments.
- dp  out  1  active-low decimal point.
- digit_idx  out  clog2(NUM_DIGITS)  index of the slot currently driven.
- frame_tick  out  1  one-cycle pulse when a full scan frame completes.

## Operation
- Prescaler slot_cnt counts 0..DIV-1 and wraps. slot_end = (slot_cnt == DIV-1).
- On slot_end, idx advances: idx+1, or 0 from NUM_DIGITS-1. There are no other states and no illegal-state hold. Encodings NUM_DIGITS..2^W-1 are unreachable; if ever entered, idx goes to 0 on the next slot_end.
- pwm_cnt (BRIGHT_W bits) increments every cycle, free-running, and wraps.
- lit = !blank_in[idx] && slot_cnt != 0 && (brightness == all-ones || pwm_cnt < brightness).
- When lit:
  - an = ~(1 << idx)
  - sseg = seg_in[idx]
  - dp = ~dp_in[idx]
- When not lit: an = all-ones, sseg = 7'h7F, dp = 1.
- frame_tick = 1 for the cycle after slot_end with idx == NUM_DIGITS-1.
- Inputs are sampled live every cycle; no latching per slot.
- Changes to seg_in, dp_in, blank_in or brightness appear on the outputs one cycle later.

## Timing
- All outputs are registered. Each output reflects the slot_cnt, idx, pwm_cnt and input values of the previous cycle.
- Reset values: slot_cnt=0, idx=0, pwm_cnt=0, an=all-ones, sseg=7'h7F, dp=1, digit_idx=0, frame_tick=0.
- Reset sampled high on edge N: outputs hold reset values from edge N through the first edge after reset is sampled low. Reset mid-slot or mid-frame aborts it with no partial-slot carry-over.
- Guard cycle: the first cycle of every slot (slot_cnt==0) has all anodes off. The output-register latency places this dark cycle on the output cycle following the index change, so a new digit's anode is never driven from the old slot's segments.
- digit_idx changes on the same output edge as the guard cycle.
- Slot length is exactly DIV cycles; frame length is exactly NUM_DIGITS*DIV cycles. frame_tick period equals frame length.
- Simultaneous events:
  - slot_end and pwm_cnt wrap may coincide; they are independent.
  - reset dominates everything.

## Structure
- Shared package sseg_pkg holds:
  - SEG_W = 7
  - SEG_BLANK = 7'h7F
  - ANODE_OFF helper function for an all-ones mask of a given width
- Package is shared with the digit encoders.
- Sub-module scan_tick_gen #(DIV) produces slot_cnt==0 and slot_end. It is reused by the stopwatch timebase.
- Index, PWM and output mux stay in sseg_scan_ctrl.

## Test plan
- **Reset:** NUM_DIGITS=4, DIV=4; assert reset 3 cycles mid-scan → outputs an=4'b1111, sseg=7'h7F, dp=1, digit_idx=0 next cycle; after release the first lit an=4'b1110 appears 2 cycles later.
- **Scan order:** DIV=4, brightness=all-ones, seg_in digits 7'h01,7'h02,7'h04,7'h08 → per slot: one guard cycle (an=1111), then 3 cycles of an=1110/sseg=01, 1101/02, 1011/04, 0111/08; frame_tick every 16 cycles.
- **Blank and dp:** blank_in=4'b0100, dp_in=4'b0010 → slot 2 all anodes off with sseg=7F; dp=0 only while an=1101.
- **Brightness:** BRIGHT_W=4, DIV=64, brightness=4 → anode low exactly 4 of every 16 cycles in the lit window; brightness=0 → an stays 1111; 15 → low all 63 non-guard cycles.
- **Wider config:** NUM_DIGITS=6, DIV=2 → idx sequence 0..5 then 0; frame_tick period 12; never two anodes low.

Source files
------------

// File: rtl/sseg_pkg.sv
// sseg_pkg: segment constants and anode-mask helper shared by the scan controller and the digit encoders
package sseg_pkg;
  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  function automatic logic [31:0] ANODE_OFF(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction
endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// sseg_scan_ctrl_if: digit data in (seg_in, dp_in, blank_in, brightness) and scan outputs (an, sseg, dp, digit_idx, frame_tick); slave = controller
interface sseg_scan_ctrl_if
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BRIGHT_W = 4
);
  localparam int IW = $clog2(NUM_DIGITS);
  logic [SEG_W*NUM_DIGITS-1:0] seg_in;
  logic [NUM_DIGITS-1:0] dp_in;
  logic [NUM_DIGITS-1:0] blank_in;
  logic [BRIGHT_W-1:0] brightness;
  logic [NUM_DIGITS-1:0] an;
  logic [SEG_W-1:0] sseg;
  logic dp;
  logic [IW-1:0] digit_idx;
  logic frame_tick;
  modport master (
    output seg_in, dp_in, blank_in, brightness,
    input an, sseg, dp, digit_idx, frame_tick
  );
  modport slave (
    input seg_in, dp_in, blank_in, brightness,
    output an, sseg, dp, digit_idx, frame_tick
  );
endinterface

// File: rtl/sseg_scan_ctrl_tick_gen.sv
// scan_tick_gen: DIV-cycle prescaler; ports clk, reset, slot_start (count==0), slot_end (count==DIV-1)
module scan_tick_gen #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic slot_start,
  output logic slot_end
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt;
  assign slot_start = cnt == '0;
  assign slot_end = cnt == CW'(DIV - 1);
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else cnt <= slot_end ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: multiplexed seven-segment scanner with PWM brightness and guard cycle; ports clk, reset, bus (sseg_scan_ctrl_if.slave)
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV = 100000,
  parameter int BRIGHT_W = 4
) (
  input logic clk,
  input logic reset,
  sseg_scan_ctrl_if.slave bus
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = NUM_DIGITS'(ANODE_OFF(NUM_DIGITS));
  logic slot_start, slot_end, lit;
  logic [IW-1:0] idx;
  logic [BRIGHT_W-1:0] pwm_cnt;
  scan_tick_gen #(.DIV(DIV)) u_tick (
    .clk(clk),
    .reset(reset),
    .slot_start(slot_start),
    .slot_end(slot_end)
  );
  // slot_start gives the guard cycle: dark while the outputs switch to the new index
  always_comb lit = !bus.blank_in[idx] && !slot_start && (&bus.brightness || pwm_cnt < bus.brightness);
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      pwm_cnt <= '0;
      bus.an <= AN_OFF;
      bus.sseg <= SEG_BLANK;
      bus.dp <= 1'b1;
      bus.digit_idx <= '0;
      bus.frame_tick <= 1'b0;
    end else begin
      // >= also pulls any unreachable encoding back to 0
      if (slot_end) idx <= idx >= IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
      bus.an <= lit ? ~(NUM_DIGITS'(1) << idx) : AN_OFF;
      bus.sseg <= lit ? bus.seg_in[SEG_W*idx +: SEG_W] : SEG_BLANK;
      bus.dp <= lit ? ~bus.dp_in[idx] : 1'b1;
      bus.digit_idx <= idx;
      bus.frame_tick <= slot_end && idx == IW'(NUM_DIGITS - 1);
    end
  end
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb_sseg_scan_ctrl: three configurations checked cycle by cycle against a cycle-count arithmetic model
module tb_sseg_scan_ctrl;
  typedef struct packed {
    logic [7:0] an;
    logic [6:0] sseg;
    logic dp;
    logic [2:0] idx;
    logic tick;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  int n = 0;
  int passes = 0;
  int total = 0;
  always #5 clk = ~clk;
  sseg_scan_ctrl_if #(.NUM_DIGITS(4), .BRIGHT_W(4)) ifa ();
  sseg_scan_ctrl_if #(.NUM_DIGITS(4), .BRIGHT_W(4)) ifb ();
  sseg_scan_ctrl_if #(.NUM_DIGITS(6), .BRIGHT_W(4)) ifc ();
  sseg_scan_ctrl #(.NUM_DIGITS(4), .DIV(4), .BRIGHT_W(4)) dut_a (.clk(clk), .reset(rst), .bus(ifa.slave));
  sseg_scan_ctrl #(.NUM_DIGITS(4), .DIV(64), .BRIGHT_W(4)) dut_b (.clk(clk), .reset(rst), .bus(ifb.slave));
  sseg_scan_ctrl #(.NUM_DIGITS(6), .DIV(2), .BRIGHT_W(4)) dut_c (.clk(clk), .reset(rst), .bus(ifc.slave));
  // n = cycles since reset release; slot position, digit and pwm phase follow by division
  function automatic exp_t model(input int nd, input int dv, input int cyc, input logic [55:0] seg,
                                 input logic [7:0] dpi, input logic [7:0] blk, input logic [3:0] br, input bit rs);
    exp_t e;
    int p, i, w;
    bit lit;
    e = '{an: 8'hFF, sseg: 7'h7F, dp: 1'b1, idx: 3'd0, tick: 1'b0};
    if (rs) return e;
    p = cyc % dv;
    i = (cyc / dv) % nd;
    w = cyc % 16;
    lit = !blk[i] && p != 0 && (br == 4'd15 || w < int'(br));
    if (lit) begin
      e.an = ~(8'd1 << i);
      e.sseg = seg[7*i +: 7];
      e.dp = ~dpi[i];
    end
    e.idx = 3'(i);
    e.tick = p == dv - 1 && i == nd - 1;
    return e;
  endfunction
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, n, obs, exp);
  endtask
  task automatic step();
    exp_t ea, eb, ec;
    bit rs;
    rs = rst;
    ea = model(4, 4, n, 56'(ifa.seg_in), 8'(ifa.dp_in), 8'(ifa.blank_in), ifa.brightness, rs);
    eb = model(4, 64, n, 56'(ifb.seg_in), 8'(ifb.dp_in), 8'(ifb.blank_in), ifb.brightness, rs);
    ec = model(6, 2, n, 56'(ifc.seg_in), 8'(ifc.dp_in), 8'(ifc.blank_in), ifc.brightness, rs);
    @(posedge clk);
    #1;
    check("a_an", 64'(ifa.an), 64'(ea.an[3:0]));
    check("a_sseg", 64'(ifa.sseg), 64'(ea.sseg));
    check("a_dp", 64'(ifa.dp), 64'(ea.dp));
    check("a_idx", 64'(ifa.digit_idx), 64'(ea.idx[1:0]));
    check("a_tick", 64'(ifa.frame_tick), 64'(ea.tick));
    check("b_an", 64'(ifb.an), 64'(eb.an[3:0]));
    check("b_sseg", 64'(ifb.sseg), 64'(eb.sseg));
    check("b_dp", 64'(ifb.dp), 64'(eb.dp));
    check("b_idx", 64'(ifb.digit_idx), 64'(eb.idx[1:0]));
    check("b_tick", 64'(ifb.frame_tick), 64'(eb.tick));
    check("c_an", 64'(ifc.an), 64'(ec.an[5:0]));
    check("c_sseg", 64'(ifc.sseg), 64'(ec.sseg));
    check("c_dp", 64'(ifc.dp), 64'(ec.dp));
    check("c_idx", 64'(ifc.digit_idx), 64'(ec.idx));
    check("c_tick", 64'(ifc.frame_tick), 64'(ec.tick));
    check("c_one_hot", 64'($countones(~ifc.an) <= 1), 64'd1);
    n = rs ? 0 : n + 1;
  endtask
  task automatic run(input int cycles, input bit rnd_data, input bit rnd_br);
    for (int k = 0; k < cycles; k++) begin
      step();
      if (rnd_data) begin
        ifa.seg_in = 28'($urandom);
        ifa.dp_in = 4'($urandom);
        ifa.blank_in = 4'($urandom) & 4'($urandom);
        ifb.seg_in = 28'($urandom);
        ifb.dp_in = 4'($urandom);
        ifb.blank_in = 4'($urandom) & 4'($urandom);
        ifc.seg_in = {10'($urandom), 32'($urandom)};
        ifc.dp_in = 6'($urandom);
        ifc.blank_in = 6'($urandom) & 6'($urandom);
      end
      if (rnd_br) begin
        ifa.brightness = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
        ifb.brightness = 4'($urandom);
        ifc.brightness = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      end
    end
  endtask
  initial begin
    ifa.seg_in = {7'h08, 7'h04, 7'h02, 7'h01};
    ifa.dp_in = '0;
    ifa.blank_in = '0;
    ifa.brightness = 4'hF;
    ifb.seg_in = 28'h0ABCDEF;
    ifb.dp_in = 4'b1010;
    ifb.blank_in = '0;
    ifb.brightness = 4'd4;
    ifc.seg_in = '0;
    ifc.dp_in = '0;
    ifc.blank_in = '0;
    ifc.brightness = 4'hF;
    run(2, 0, 0);
    rst = 0;
    run(40, 0, 0);
    ifa.blank_in = 4'b0100;
    ifa.dp_in = 4'b0010;
    run(300, 0, 0);
    ifb.brightness = 4'd0;
    run(140, 0, 0);
    ifb.brightness = 4'hF;
    run(140, 0, 0);
    run(37, 1, 1);
    rst = 1;
    run(3, 1, 1);
    rst = 0;
    run(700, 1, 1);
    rst = 1;
    run(1, 1, 1);
    rst = 0;
    run(400, 1, 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
